// File: rtl/main_control_fsm.sv
// Multicycle MIPS-style main controller: Moore control outputs decoded from the
// current state, plus pc_en, illegal_op and instr_done which also look at op/zero.
module main_control_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       branch,
    output logic       pc_write,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR  = 4'd5,  EXECUTE = 4'd6, ALUWB  = 4'd7,
        BEQ     = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;
    logic   op_ok;
    logic   ir_write_s, pc_write_s, mem_write_s, reg_write_s, done_s;

    assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                   (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // Moore decode; unencoded states fall through to all-zero defaults.
    always_comb begin
        iord        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        branch      = 1'b0;
        pc_write_s  = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = 2'b01;
            end
            DECODE:  alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                done_s      = 1'b1;
            end
            MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                done_s      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                done_s      = 1'b1;
            end
            ADDIWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                done_s    = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write_s = 1'b1;
                done_s     = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset_n so they drop the instant reset asserts.
    assign ir_write   = ir_write_s  & reset_n;
    assign pc_write   = pc_write_s  & reset_n;
    assign mem_write  = mem_write_s & reset_n;
    assign reg_write  = reg_write_s & reset_n;
    assign illegal_op = (state_q == DECODE) & ~op_ok & reset_n;
    assign instr_done = (done_s | illegal_op) & reset_n;
    assign pc_en      = pc_write | (branch & zero);
    assign state      = state_q;
endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench: driver pushes expected per-cycle outputs from an instruction-level
// model; a negedge monitor pops and compares against the DUT.
module tb_main_control_fsm;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       branch, pc_write, pc_en, instr_done, illegal_op;
    logic [3:0] state;

    typedef struct packed {
        logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       branch, pc_write, pc_en, instr_done, illegal_op;
        logic [3:0] state;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   running = 1'b1;

    main_control_fsm dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .branch(branch),
        .pc_write(pc_write), .pc_en(pc_en), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit supported(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    // Instruction-level model: list of states visited, starting at FETCH.
    function automatic void seq_for(input logic [5:0] o, output int s[$]);
        s = {0, 1};
        case (o)
            6'b100011: s = {s, 2, 3, 4};
            6'b101011: s = {s, 2, 5};
            6'b000000: s = {s, 6, 7};
            6'b000100: s = {s, 8};
            6'b001000: s = {s, 9, 10};
            6'b000010: s = {s, 11};
            default:   ;
        endcase
    endfunction

    function automatic obs_t exp_out(input int s, input logic [5:0] o, input logic z,
                                     input logic rst_n);
        obs_t e = '0;
        e.state = 4'(s);
        case (s)
            0:  begin e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; end
            1:  e.alu_src_b = 2'b11;
            2, 9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.iord = 1; e.mem_write = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1; end
            10: e.reg_write = 1;
            11: begin e.pc_src = 2'b10; e.pc_write = 1; end
            default: ;
        endcase
        e.illegal_op = (s == 1) && !supported(o);
        e.instr_done = (s inside {4, 5, 7, 8, 10, 11}) || e.illegal_op;
        if (!rst_n) begin
            e.ir_write = 0; e.pc_write = 0; e.mem_write = 0; e.reg_write = 0;
            e.instr_done = 0; e.illegal_op = 0;
        end
        e.pc_en = e.pc_write | (e.branch & z);
        return e;
    endfunction

    function automatic obs_t sample();
        return {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, branch, pc_write, pc_en, instr_done,
                illegal_op, state};
    endfunction

    always @(negedge clk) begin
        if (running && exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = sample();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t state=%0d op=%b: got %h expected %h",
                         $time, e.state, op, a, e);
            end
        end
    end

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset_n = 1'b0;
            zero = 1'($urandom);
            exp_q.push_back(exp_out(0, op, zero, 1'b0));
        end
    endtask

    // zfix < 0 means randomize zero every cycle; max_steps < 0 runs the whole instruction.
    task automatic run_instr(input logic [5:0] o, input int zfix, input int max_steps);
        int s[$];
        seq_for(o, s);
        for (int k = 0; k < s.size(); k++) begin
            if (max_steps >= 0 && k >= max_steps) break;
            @(posedge clk); #1;
            reset_n = 1'b1;
            op = o;
            zero = (zfix < 0) ? 1'($urandom) : 1'(zfix);
            exp_q.push_back(exp_out(s[k], o, zero, 1'b1));
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                                6'b000100, 6'b001000, 6'b000010};
        logic [5:0] o;
        if ($urandom_range(6, 0) < 6) return ops[$urandom_range(5, 0)];
        do o = 6'($urandom); while (supported(o));
        return o;
    endfunction

    initial begin
        reset_n = 1'b0;
        reset_cycles(3);
        run_instr(6'b100011, -1, -1);
        run_instr(6'b101011, -1, -1);
        run_instr(6'b000000, -1, -1);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b001000, -1, -1);
        run_instr(6'b000010, -1, -1);
        run_instr(6'b111111, -1, -1);

        // Reset between edges while in MEMRD: state and strobes must drop with no edge.
        run_instr(6'b100011, -1, 4);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || mem_write || reg_write || ir_write || pc_write || pc_en ||
            instr_done || illegal_op) begin
            miscompares++;
            $display("FAIL async_reset: state=%0d mw=%b rw=%b irw=%b pcw=%b pce=%b, expected state 0 and strobes 0",
                     state, mem_write, reg_write, ir_write, pc_write, pc_en);
        end
        reset_cycles(2);
        run_instr(6'b100011, -1, -1);

        for (int i = 0; i < 300; i++) run_instr(rand_op(), -1, -1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
